// File: rtl/tx_crc_sequencer.sv
// Tx frame controller: gates source bits to the encoder, runs CRC_A and optionally appends it LSB first.
// Optional macro TX_CRC_INJECT_ERR_EN adds inject_crc_err, which flips the first appended CRC bit.
module tx_crc_sequencer #(
  parameter logic [15:0] CRC_INIT = 16'h6363,
  parameter logic [15:0] CRC_POLY = 16'h8408
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fdt_trigger,
  input  logic        tx_append_crc,
`ifdef TX_CRC_INJECT_ERR_EN
  input  logic        inject_crc_err,
`endif
  input  logic        in_data,
  input  logic        in_data_valid,
  input  logic        in_last,
  output logic        in_req,
  output logic        out_data,
  output logic        out_data_valid,
  output logic        out_last,
  input  logic        out_req,
  output logic [15:0] crc,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_CRC  = 2'd2;

  logic [1:0]  r_state;
  logic [15:0] r_crc;
  logic [3:0]  r_cnt;
  logic        r_append;
  logic        r_inject;

  logic        w_in_req;
  logic        w_out_data;
  logic        w_out_valid;
  logic        w_out_last;
  logic        w_xfer;
  logic        w_start;
  logic        w_inject_req;
  logic [15:0] w_crc_tx;

  // One bit of the reflected CRC_A LFSR.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
    crc_step = (c >> 1) ^ (((c[0] ^ d) == 1'b1) ? CRC_POLY : 16'h0000);
  endfunction

`ifdef TX_CRC_INJECT_ERR_EN
  assign w_inject_req = inject_crc_err;
`else
  assign w_inject_req = 1'b0;
`endif

  assign w_crc_tx = r_crc ^ {15'd0, r_inject};
  assign w_start  = (r_state == ST_IDLE) && fdt_trigger && in_data_valid;
  assign w_xfer   = w_out_valid && out_req;

  // Output mux: DATA is a zero-latency pass-through, CRC replays the frozen register.
  always_comb begin
    w_in_req    = 1'b0;
    w_out_data  = 1'b0;
    w_out_valid = 1'b0;
    w_out_last  = 1'b0;
    case (r_state)
      ST_DATA: begin
        w_in_req    = out_req;
        w_out_data  = in_data;
        w_out_valid = in_data_valid;
        w_out_last  = in_last && !r_append;
      end
      ST_CRC: begin
        w_in_req    = 1'b0;
        w_out_data  = w_crc_tx[r_cnt];
        w_out_valid = 1'b1;
        w_out_last  = (r_cnt == 4'd15);
      end
      default: begin
        w_in_req    = 1'b0;
        w_out_data  = 1'b0;
        w_out_valid = 1'b0;
        w_out_last  = 1'b0;
      end
    endcase
  end

  // Frame state, CRC register and appended-bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_crc    <= CRC_INIT;
      r_cnt    <= 4'd0;
      r_append <= 1'b0;
      r_inject <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_append <= tx_append_crc;
            r_inject <= w_inject_req;
            r_crc    <= CRC_INIT;
            r_cnt    <= 4'd0;
            r_state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_xfer) begin
            r_crc <= crc_step(r_crc, in_data);
            if (in_last) begin
              r_cnt   <= 4'd0;
              r_state <= r_append ? ST_CRC : ST_IDLE;
            end
          end
        end
        ST_CRC: begin
          if (w_xfer) begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign in_req         = w_in_req;
  assign out_data       = w_out_data;
  assign out_data_valid = w_out_valid;
  assign out_last       = w_out_last;
  assign crc            = r_crc;
  assign busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_tx_crc_sequencer.sv
// Scoreboard bench for tx_crc_sequencer: expected bits queued per frame, monitor pops on each output transfer.
module tb_tx_crc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        fdt_trigger;
  logic        tx_append_crc;
  logic        inject_crc_err;
  logic        in_data;
  logic        in_data_valid;
  logic        in_last;
  logic        in_req;
  logic        out_data;
  logic        out_data_valid;
  logic        out_last;
  logic        out_req;
  logic [15:0] crc;
  logic        busy;

  always #5 clk = ~clk;

  tx_crc_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .fdt_trigger   (fdt_trigger),
    .tx_append_crc (tx_append_crc),
`ifdef TX_CRC_INJECT_ERR_EN
    .inject_crc_err(inject_crc_err),
`endif
    .in_data       (in_data),
    .in_data_valid (in_data_valid),
    .in_last       (in_last),
    .in_req        (in_req),
    .out_data      (out_data),
    .out_data_valid(out_data_valid),
    .out_last      (out_last),
    .out_req       (out_req),
    .crc           (crc),
    .busy          (busy)
  );

  typedef struct packed {
    logic d;
    logic l;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   n_popped = 0;
  bit   chk_busy = 1'b0;
  bit   rnd_req  = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Encoder-side request: constant or random per cycle.
  initial begin
    out_req = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_req = rnd_req ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  // Monitor: compare every output transfer against the scoreboard queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_busy) begin
        chk("busy_fall", busy, 16'd0);
        chk_busy = 1'b0;
      end
      if (!rst && out_data_valid && out_req) begin
        if (q.size() == 0) begin
          chk("unexpected_bit", 16'd1, 16'd0);
        end else begin
          e = q.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_last", out_last, e.l);
          chk("busy_xfer", busy, 16'd1);
          if (e.l) chk_busy = 1'b1;
        end
        n_popped++;
      end
    end
  end

  // Queue the expected bits, trigger the frame and feed all data bits.
  task automatic send(input logic [15:0] data, input int nbits, input bit app,
                      input bit inj, input bit stall, input logic [15:0] exp_crc);
    logic [15:0] tx;
    int to;
    for (int i = 0; i < nbits; i++) q.push_back('{d: data[i], l: (!app && i == nbits - 1)});
    if (app) begin
      tx = exp_crc ^ {15'd0, inj};
      for (int j = 0; j < 16; j++) q.push_back('{d: tx[j], l: (j == 15)});
    end
    in_data        = data[0];
    in_last        = (nbits == 1);
    in_data_valid  = 1'b1;
    tx_append_crc  = app;
    inject_crc_err = inj;
    fdt_trigger    = 1'b1;
    @(posedge clk);
    #1;
    fdt_trigger    = 1'b0;
    tx_append_crc  = ~app;
    inject_crc_err = ~inj;
    for (int i = 0; i < nbits; i++) begin
      if (i > 0) begin
        if (stall && ($urandom_range(1, 0) == 1)) begin
          in_data_valid = 1'b0;
          @(posedge clk);
          #1;
        end
        in_data       = data[i];
        in_last       = (i == nbits - 1);
        in_data_valid = 1'b1;
        fdt_trigger   = (i == 1);
      end
      to = 0;
      while (to < 200) begin
        @(negedge clk);
        if (in_req) break;
        to++;
      end
      chk("in_xfer_timeout", 16'(to >= 200), 16'd0);
      @(posedge clk);
      #1;
      fdt_trigger = 1'b0;
    end
    in_data_valid = 1'b0;
    in_last       = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] data, input int nbits, input bit app,
                           input bit inj, input bit stall, input logic [15:0] exp_crc);
    int to;
    send(data, nbits, app, inj, stall, exp_crc);
    to = 0;
    while (busy && to < 300) begin
      @(posedge clk);
      #1;
      to++;
    end
    chk("busy_timeout", 16'(to >= 300), 16'd0);
    @(posedge clk);
    #1;
    chk("crc_final", crc, exp_crc);
    chk("queue_empty", 16'(q.size()), 16'd0);
  endtask

  initial begin
    int base;
    int to;
    rst = 1'b1; fdt_trigger = 1'b0; tx_append_crc = 1'b0; inject_crc_err = 1'b0;
    in_data = 1'b0; in_data_valid = 1'b0; in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_crc", crc, 16'h6363);
    chk("rst_busy", busy, 16'd0);
    chk("rst_in_req", in_req, 16'd0);
    chk("rst_out_valid", out_data_valid, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    run_frame(16'h0000, 16, 1'b1, 1'b0, 1'b0, 16'h1EA0);
    run_frame(16'h3412, 16, 1'b1, 1'b0, 1'b0, 16'hCF26);
    run_frame(16'h00A5, 8, 1'b0, 1'b0, 1'b0, 16'hA359);

    // Trigger without valid data must not start a frame.
    in_data_valid = 1'b0;
    fdt_trigger   = 1'b1;
    @(posedge clk);
    #1;
    fdt_trigger = 1'b0;
    chk("idle_trig_busy", busy, 16'd0);
    chk("idle_trig_in_req", in_req, 16'd0);
    chk("idle_trig_crc", crc, 16'hA359);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_trig_busy_later", busy, 16'd0);
    run_frame(16'h3412, 16, 1'b1, 1'b0, 1'b0, 16'hCF26);

    rnd_req = 1'b1;
    run_frame(16'h0000, 16, 1'b1, 1'b0, 1'b1, 16'h1EA0);
    rnd_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset while the CRC counter sits at 7.
    base = n_popped;
    send(16'h0000, 16, 1'b1, 1'b0, 1'b0, 16'h1EA0);
    to = 0;
    while (n_popped < base + 23 && to < 200) begin
      @(posedge clk);
      to++;
    end
    chk("crc7_timeout", 16'(to >= 200), 16'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_crc", crc, 16'h6363);
    chk("arst_busy", busy, 16'd0);
    chk("arst_in_req", in_req, 16'd0);
    chk("arst_out_valid", out_data_valid, 16'd0);
    chk("arst_out_data", out_data, 16'd0);
    chk("arst_out_last", out_last, 16'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    run_frame(16'h3412, 16, 1'b1, 1'b0, 1'b0, 16'hCF26);

`ifdef TX_CRC_INJECT_ERR_EN
    run_frame(16'h0000, 16, 1'b1, 1'b1, 1'b0, 16'h1EA0);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
